instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  - RESET_PC, 32'h0000_0000, first fetch address after reset.
  - QDEPTH, 2, instruction-queue entries, which also bound outstanding requests.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  - clk, in, 1, sole clock, rising edge.
  - reset_n, in, 1, asynchronous active-low reset.
  - imem_req_valid, out, 1, fetch request valid.
  - imem_req_ready, in, 1, memory accepts request.
  - imem_addr, out, 32, fetch address, word aligned.
  - imem_rsp_valid, in, 1, response data valid (in order, no backpressure).
  - imem_rsp_data, in, 32, fetched instruction word.
  - redirect_valid, in, 1, branch/jal taken; load new PC.
  - redirect_pc, in, 32, target PC; bits [1:0] ignored.
  - if_valid, out, 1, instruction available to decode.
  - if_ready, in, 1, decode consumes instruction.
  - if_instr, out, 32, instruction word to decode/extend.
  - if_pc, out, 32, PC of if_instr.
  - if_pcplus4, out, 32, if_pc + 4.
REQ-003 One clock domain SHALL be used; reset SHALL be asynchronous and active-low, with ports clk and reset_n.

Function
REQ-004 Fetch PC register SHALL drive imem_addr, with imem_addr[1:0] always 2'b00.
REQ-005 A request SHALL transfer only in a cycle where imem_req_valid and imem_req_ready are both high; the PC SHALL then advance by 4, wrapping at 2^32 (32'hFFFF_FFFC -> 0).
REQ-006 imem_req_valid SHALL be high iff (queue count + inflight count) < QDEPTH and redirect_valid is low.
REQ-007 Withdrawing an unaccepted request on redirect SHALL be legal; memory samples only on a valid&&ready transfer.
REQ-008 Responses SHALL be in order, with a minimum latency of 1 cycle after request transfer; inflight SHALL increment on request transfer and decrement on imem_rsp_valid, with both in the same cycle leaving it unchanged.
REQ-009 Each non-dropped response SHALL push {pc, instr} into the queue; the queue cannot overflow, by REQ-006.
REQ-010 The queue head SHALL drive if_instr, if_pc and if_pcplus4; if_valid SHALL equal queue not-empty.
REQ-011 A pop SHALL occur when if_valid and if_ready are both high; push and pop in the same cycle SHALL keep count unchanged.
REQ-012 A response arriving into an empty queue SHALL be visible on if_valid the next cycle (1-cycle rsp-to-decode latency, no bypass).
REQ-013 On redirect_valid, in the same cycle:
  - the queue SHALL flush, so if_valid is low the next cycle;
  - PC <= {redirect_pc[31:2], 2'b00};
  - drop_cnt <= inflight after this cycle's response is accounted for.
REQ-014 While drop_cnt > 0, each imem_rsp_valid SHALL be discarded and SHALL decrement drop_cnt.
REQ-015 A response coinciding with redirect_valid SHALL be discarded.
REQ-016 A simultaneous redirect and if_ready SHALL have the redirect win; the popped entry counts as consumed, with no double pop.
REQ-017 Back-to-back redirects SHALL each re-flush; the last target SHALL win.
REQ-018 Counter widths SHALL be $clog2(QDEPTH+1), with no wrap possible.

Reset
REQ-019 While reset_n is low:
  - PC = RESET_PC;
  - queue empty;
  - inflight = 0 and drop_cnt = 0;
  - if_valid = 0 and imem_req_valid = 0;
  - if_instr, if_pc and if_pcplus4 = 0.
REQ-020 Responses arriving during reset, or pending at reset assertion mid-operation, SHALL be lost with no side effects.
REQ-021 The first request SHALL be issued in the first cycle after reset_n deasserts, to address RESET_PC.

Structure
REQ-022 Package riscv_pkg SHALL hold:
  - XLEN = 32;
  - the default RESET_PC value;
  - typedef fetch_entry_t {pc[31:0], instr[31:0]}.
REQ-023 Sub-module fetch_queue SHALL be the parameterized QDEPTH FIFO of fetch_entry_t, with push, pop, flush, empty and count.
REQ-024 if_instr SHALL connect directly to the decode and immediate-extend stage; no decoding SHALL occur here.

Verification
REQ-025 Reset, then memory always ready with 1-cycle latency -> addresses 0x0, 0x4, 0x8, ...; if_valid first high 2 cycles after the first request; if_pc increments by 4.
REQ-026 if_ready held low -> at most 2 requests issued; imem_req_valid low while full; if_ready high releases one request per pop.
REQ-027 Redirect to 0x0000_0103 with 2 responses in flight -> next imem_addr = 0x100; both stale responses dropped; first if_pc = 0x100.
REQ-028 Redirect, response and if_ready in the same cycle -> response discarded; queue empty next cycle; no pop underflow.
REQ-029 Redirect to 0xFFFF_FFFC -> fetch addresses 0xFFFF_FFFC then 0x0000_0000; if_pcplus4 = 0 for the first entry.
REQ-030 reset_n pulsed low mid-stream with 1 in flight -> all outputs at reset values asynchronously; the late response is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: data width, reset vector and fetch-queue payload.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, instr} entries; flush has priority over push and pop.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned QDEPTH = 2,
    localparam int unsigned CW = $clog2(QDEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic          empty,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    fetch_entry_t  mem_q [QDEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pointer and occupancy next-state
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_push  = push && (count_q != CW'(QDEPTH)) && !flush;
        do_pop   = pop && (count_q != '0) && !flush;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_d = count_q + CW'(1);
            else if (do_pop && !do_push) count_d = count_q - CW'(1);
        end
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            for (int unsigned i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            if (do_push) mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign empty = empty_q;
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues word fetches, tracks in-flight responses, drops stale ones
// after a redirect and queues {pc, instr} for decode.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pcplus4
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic            req_fire;
    logic            rsp_live;
    logic            rsp_keep;
    logic            q_empty;
    logic [CW-1:0]   q_count;
    fetch_entry_t    q_head;
    fetch_entry_t    q_push_data;
    logic [XLEN-1:0] target_pc;
    logic            unused_redirect_lsb;

    assign target_pc           = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Occupancy bound: queued plus outstanding never exceeds the queue size
    assign imem_req_valid = reset_n && !redirect_valid &&
                            ((CW+1)'(q_count) + (CW+1)'(inflight_q) < (CW+1)'(QDEPTH));
    assign req_fire = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding belongs to a pre-reset request
    assign rsp_live = imem_rsp_valid && (inflight_q != '0);
    assign rsp_keep = rsp_live && !redirect_valid && (drop_q == '0);

    always_comb begin
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_live);
        drop_d     = drop_q;
        if (redirect_valid) begin
            pc_d     = target_pc;
            rsp_pc_d = target_pc;
            drop_d   = inflight_q - CW'(rsp_live);
        end else begin
            if (req_fire) pc_d = pc_q + 32'd4;
            if (rsp_keep) rsp_pc_d = rsp_pc_q + 32'd4;
            if (rsp_live && (drop_q != '0)) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= {RESET_PC[XLEN-1:2], 2'b00};
            rsp_pc_q   <= {RESET_PC[XLEN-1:2], 2'b00};
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    assign q_push_data = '{pc: rsp_pc_q, instr: imem_rsp_data};

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (reset_n),
        .push      (rsp_keep),
        .push_data (q_push_data),
        .pop       (if_valid && if_ready),
        .flush     (redirect_valid),
        .empty     (q_empty),
        .count     (q_count),
        .head      (q_head)
    );

    assign imem_addr  = {pc_q[XLEN-1:2], 2'b00};
    assign if_valid   = !q_empty;
    assign if_instr   = if_valid ? q_head.instr : '0;
    assign if_pc      = if_valid ? q_head.pc : '0;
    assign if_pcplus4 = if_valid ? q_head.pc + 32'd4 : '0;

endmodule
